// File: rtl/cond_pipe_unit.sv
// cond_pipe_unit: per-lane condition-code evaluation against {N,Z,C,V} with a one-deep output register.
// Optional IT-block sequencer overriding lane 0 is compiled in when COND_IT_BLOCK_EN is defined.
module cond_pipe_unit #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*LANES-1:0] cond,
  input  logic               flags_we,
  input  logic [3:0]         flags_in,
  input  logic               out_stall,
  output logic               out_valid,
  output logic [LANES-1:0]   cond_pass,
  output logic [3:0]         status_out
`ifdef COND_IT_BLOCK_EN
  ,
  input  logic               it_start,
  input  logic [3:0]         it_cond,
  input  logic [1:0]         it_len,
  input  logic [3:0]         it_te,
  output logic               it_active
`endif
);

  localparam int unsigned CW = 4 * LANES;

  function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (code)
      4'h0:    eval_cond = z;
      4'h1:    eval_cond = !z;
      4'h2:    eval_cond = c;
      4'h3:    eval_cond = !c;
      4'h4:    eval_cond = n;
      4'h5:    eval_cond = !n;
      4'h6:    eval_cond = v;
      4'h7:    eval_cond = !v;
      4'h8:    eval_cond = c & !z;
      4'h9:    eval_cond = !c | z;
      4'hA:    eval_cond = (n == v);
      4'hB:    eval_cond = (n != v);
      4'hC:    eval_cond = !z & (n == v);
      4'hD:    eval_cond = z | (n != v);
      4'hE:    eval_cond = 1'b1;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  logic [3:0]       status_q, status_d;
  logic             out_valid_q, out_valid_d;
  logic [LANES-1:0] pass_q, pass_d, pass_c;
  logic [CW-1:0]    eff_cond_c;
  logic [3:0]       flags_c;
  logic             accept_c;

  assign in_ready   = !out_valid_q | !out_stall;
  assign accept_c   = in_valid & in_ready;
  assign flags_c    = ((BYPASS != 32'd0) && flags_we) ? flags_in : status_q;
  assign out_valid  = out_valid_q;
  assign cond_pass  = pass_q;
  assign status_out = status_q;

`ifdef COND_IT_BLOCK_EN
  typedef enum logic {IT_IDLE, IT_ACTIVE} it_state_e;

  it_state_e  state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] it_cond_q, it_cond_d;
  logic [3:0] it_te_q, it_te_d;
  logic       ovr_c;
  logic [3:0] ovr_code_c;

  // A start always (re)loads the block; the transaction accepted alongside it is left alone.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    it_cond_d = it_cond_q;
    it_te_d   = it_te_q;
    ovr_c     = 1'b0;
    case (state_q)
      IT_IDLE: begin
        if (it_start) begin
          state_d   = IT_ACTIVE;
          count_d   = 3'(it_len) + 3'd1;
          idx_d     = 2'd0;
          it_cond_d = it_cond;
          it_te_d   = it_te;
        end
      end
      IT_ACTIVE: begin
        if (it_start) begin
          count_d   = 3'(it_len) + 3'd1;
          idx_d     = 2'd0;
          it_cond_d = it_cond;
          it_te_d   = it_te;
        end else if (accept_c) begin
          ovr_c   = 1'b1;
          count_d = count_q - 3'd1;
          idx_d   = idx_q + 2'd1;
          if (count_q == 3'd1) state_d = IT_IDLE;
        end
      end
      default: state_d = IT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IT_IDLE;
      count_q   <= 3'd0;
      idx_q     <= 2'd0;
      it_cond_q <= 4'h0;
      it_te_q   <= 4'h0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      it_cond_q <= it_cond_d;
      it_te_q   <= it_te_d;
    end
  end

  assign it_active  = (state_q == IT_ACTIVE);
  assign ovr_code_c = it_te_q[idx_q] ? it_cond_q : (it_cond_q ^ 4'h1);

  always_comb begin
    eff_cond_c = cond;
    if (ovr_c) eff_cond_c[3:0] = ovr_code_c;
  end
`else
  assign eff_cond_c = cond;
`endif

  always_comb begin
    pass_c = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      pass_c[l] = eval_cond(eff_cond_c[4*l +: 4], flags_c);
    end
  end

  // Output register holds while stalled; flag writes are never blocked by the stall.
  always_comb begin
    status_d    = status_q;
    out_valid_d = out_valid_q;
    pass_d      = pass_q;
    if (flags_we) status_d = flags_in;
    if (accept_c) begin
      out_valid_d = 1'b1;
      pass_d      = pass_c;
    end else if (!out_stall) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q    <= 4'h0;
      out_valid_q <= 1'b0;
      pass_q      <= '0;
    end else begin
      status_q    <= status_d;
      out_valid_q <= out_valid_d;
      pass_q      <= pass_d;
    end
  end

endmodule
